// File: rtl/cam_soc_hs_pkg.sv
// Shared definitions for the camera SoC hardware sequencer.
// Contents:
//   state_t   - sequencer FSM states
//   REQ_BIT   - to_hw_sig bit carrying the REQ level
//   ABORT_BIT - to_hw_sig bit carrying the ABORT level
//   DONE_BIT  - from_hw_sig bit reporting DONE
//   ERR_BIT   - from_hw_sig bit reporting ERROR
package cam_soc_hs_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARMED,
    ST_BUSY,
    ST_DONE,
    ST_ERROR
  } state_t;

  localparam int REQ_BIT   = 0;
  localparam int ABORT_BIT = 1;
  localparam int DONE_BIT  = 0;
  localparam int ERR_BIT   = 1;

endpackage

// File: rtl/cam_soc_sync_edge.sv
// Two-flop synchronizer followed by a rising-edge detector.
// Ports:
//   clk   - destination clock
//   reset - synchronous, active-high; clears every flop
//   din   - asynchronous input level
//   rise  - combinational one-cycle pulse on a synchronized 0->1 edge
module cam_soc_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic rise
);

  logic meta;
  logic sync;
  logic sync_d;
  logic [2:0] fill;

  // fill marks when meta/sync/sync_d all hold real samples taken after
  // reset; until then the zeros left by reset could look like a low level
  // and a high input present at reset release would fake an edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta   <= 1'b0;
      sync   <= 1'b0;
      sync_d <= 1'b0;
      fill   <= 3'b000;
    end else begin
      meta   <= din;
      sync   <= meta;
      sync_d <= sync;
      fill   <= {fill[1:0], 1'b1};
    end
  end

  assign rise = sync & ~sync_d & fill[2];

endmodule

// File: rtl/cam_soc_hw_seq_ctrl.sv
// Frame sequencer between the CPU command port, the camera vsync and the
// encryption engine.
// Parameters:
//   TIMEOUT_CYCLES - cycles allowed in BUSY before a timeout error
//   TMO_W          - timeout counter width (TIMEOUT_CYCLES < 2**TMO_W)
// Ports:
//   clk          - single clock
//   reset        - synchronous, active-high
//   to_hw_sig    - CPU command: bit0 REQ, bit1 ABORT (levels)
//   vsync        - camera frame sync, asynchronous
//   engine_done  - one-cycle pulse when the engine finishes a frame
//   frame_start  - one-cycle pulse starting the engine
//   engine_abort - one-cycle pulse cancelling the engine
//   from_hw_sig  - CPU status: bit0 DONE, bit1 ERROR
//   busy         - high while ARMED or BUSY
//   frame_count  - completed-frame counter (wraps)
module cam_soc_hw_seq_ctrl
  import cam_soc_hs_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 2000000,
  parameter int TMO_W          = 24
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  to_hw_sig,
  input  logic        vsync,
  input  logic        engine_done,
  output logic        frame_start,
  output logic        engine_abort,
  output logic [1:0]  from_hw_sig,
  output logic        busy,
  output logic [15:0] frame_count
);

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  state_t           state;
  state_t           state_nxt;
  logic [1:0]       cmd;
  logic [TMO_W-1:0] tmo;
  logic             vs_rise;
  logic             start_nxt;
  logic             abort_nxt;
  logic             count_inc;
  logic             req;
  logic             abort;

  cam_soc_sync_edge u_vsync (
    .clk   (clk),
    .reset (reset),
    .din   (vsync),
    .rise  (vs_rise)
  );

  assign req   = cmd[REQ_BIT];
  assign abort = cmd[ABORT_BIT];

  // Next-state decode. Within BUSY the order of the checks sets priority:
  // ABORT beats engine_done, and engine_done beats the timeout.
  always_comb begin
    state_nxt = state;
    start_nxt = 1'b0;
    abort_nxt = 1'b0;
    count_inc = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req && !abort) state_nxt = ST_ARMED;
      end
      ST_ARMED: begin
        if (abort) begin
          state_nxt = ST_ERROR;
        end else if (!req) begin
          state_nxt = ST_IDLE;
        end else if (vs_rise) begin
          state_nxt = ST_BUSY;
          start_nxt = 1'b1;
        end
      end
      ST_BUSY: begin
        if (abort) begin
          state_nxt = ST_ERROR;
          abort_nxt = 1'b1;
        end else if (engine_done) begin
          state_nxt = ST_DONE;
          count_inc = 1'b1;
        end else if (tmo == TMO_LAST) begin
          state_nxt = ST_ERROR;
          abort_nxt = 1'b1;
        end
      end
      ST_DONE, ST_ERROR: begin
        if (!req) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State, command register, timeout counter and registered outputs. The
  // outputs are loaded from the next-state decode so they line up with the
  // state they describe in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      cmd          <= 2'b00;
      tmo          <= '0;
      frame_start  <= 1'b0;
      engine_abort <= 1'b0;
      from_hw_sig  <= 2'b00;
      busy         <= 1'b0;
      frame_count  <= 16'h0000;
    end else begin
      state        <= state_nxt;
      cmd          <= to_hw_sig;
      frame_start  <= start_nxt;
      engine_abort <= abort_nxt;
      busy         <= (state_nxt == ST_ARMED) || (state_nxt == ST_BUSY);
      from_hw_sig[DONE_BIT] <= (state_nxt == ST_DONE);
      from_hw_sig[ERR_BIT]  <= (state_nxt == ST_ERROR);
      if (start_nxt) begin
        tmo <= '0;
      end else if (state == ST_BUSY) begin
        tmo <= tmo + 1'b1;
      end
      if (count_inc) frame_count <= frame_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_cam_soc_hw_seq_ctrl.sv
// Directed bench for cam_soc_hw_seq_ctrl. Two instances share all inputs:
// dut_a has a long timeout for the functional frames, dut_b uses a 50-cycle
// timeout for the timeout and done-versus-timeout scenarios.
module tb_cam_soc_hw_seq_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  to_hw_sig = 2'b00;
  logic        vsync = 1'b0;
  logic        engine_done = 1'b0;

  logic        frame_start_a, engine_abort_a, busy_a;
  logic [1:0]  from_hw_sig_a;
  logic [15:0] frame_count_a;
  logic        frame_start_b, engine_abort_b, busy_b;
  logic [1:0]  from_hw_sig_b;
  logic [15:0] frame_count_b;

  int tests_run = 0;
  int tests_failed = 0;
  int fs_cnt_a = 0;
  int ab_cnt_a = 0;
  int ab_cnt_b = 0;
  int both_high = 0;
  int fs_mark;
  int ab_mark;

  always #5 clk = ~clk;

  cam_soc_hw_seq_ctrl #(.TIMEOUT_CYCLES(1000), .TMO_W(10)) dut_a (
    .clk          (clk),
    .reset        (reset),
    .to_hw_sig    (to_hw_sig),
    .vsync        (vsync),
    .engine_done  (engine_done),
    .frame_start  (frame_start_a),
    .engine_abort (engine_abort_a),
    .from_hw_sig  (from_hw_sig_a),
    .busy         (busy_a),
    .frame_count  (frame_count_a)
  );

  cam_soc_hw_seq_ctrl #(.TIMEOUT_CYCLES(50), .TMO_W(8)) dut_b (
    .clk          (clk),
    .reset        (reset),
    .to_hw_sig    (to_hw_sig),
    .vsync        (vsync),
    .engine_done  (engine_done),
    .frame_start  (frame_start_b),
    .engine_abort (engine_abort_b),
    .from_hw_sig  (from_hw_sig_b),
    .busy         (busy_b),
    .frame_count  (frame_count_b)
  );

  // Pulse counters and the start/abort exclusivity monitor.
  always @(posedge clk) begin
    if (frame_start_a) fs_cnt_a <= fs_cnt_a + 1;
    if (engine_abort_a) ab_cnt_a <= ab_cnt_a + 1;
    if (engine_abort_b) ab_cnt_b <= ab_cnt_b + 1;
    if ((frame_start_a && engine_abort_a) || (frame_start_b && engine_abort_b))
      both_high <= both_high + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [1:0] cmd, input logic vs,
                               input logic done);
    to_hw_sig   = cmd;
    vsync       = vs;
    engine_done = done;
  endtask

  task automatic doReset();
    reset = 1'b1;
    applyStimulus(2'b00, 1'b0, 1'b0);
    tick(3);
    reset = 1'b0;
  endtask

  // Raise REQ, then a vsync edge; returns one step after the edge that
  // enters BUSY (first BUSY cycle, frame_start visible).
  task automatic runToBusy();
    applyStimulus(2'b01, 1'b0, 1'b0);
    tick(2);
    vsync = 1'b1;
    tick(3);
  endtask

  initial begin
    // Reset state
    doReset();
    checkOutput("rst_fs", {31'd0, frame_start_a}, 32'd0);
    checkOutput("rst_abort", {31'd0, engine_abort_a}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy_a}, 32'd0);
    checkOutput("rst_status", {30'd0, from_hw_sig_a}, 32'd0);
    checkOutput("rst_count", {16'd0, frame_count_a}, 32'd0);

    // ABORT in IDLE is ignored; REQ with ABORT does not arm
    applyStimulus(2'b11, 1'b0, 1'b0);
    tick(4);
    checkOutput("idle_abort_busy", {31'd0, busy_a}, 32'd0);
    checkOutput("idle_abort_status", {30'd0, from_hw_sig_a}, 32'd0);

    // Normal frame: vsync 10 cycles after REQ, done 100 cycles after start
    doReset();
    fs_mark = fs_cnt_a;
    applyStimulus(2'b01, 1'b0, 1'b0);
    tick(2);
    checkOutput("nf_armed_busy", {31'd0, busy_a}, 32'd1);
    tick(8);
    vsync = 1'b1;
    tick(2);
    checkOutput("nf_fs_early", {31'd0, frame_start_a}, 32'd0);
    tick(1);
    checkOutput("nf_fs_pulse", {31'd0, frame_start_a}, 32'd1);
    tick(1);
    checkOutput("nf_fs_low", {31'd0, frame_start_a}, 32'd0);
    tick(98);
    engine_done = 1'b1;
    tick(1);
    engine_done = 1'b0;
    checkOutput("nf_status", {30'd0, from_hw_sig_a}, 32'h1);
    checkOutput("nf_count", {16'd0, frame_count_a}, 32'd1);
    checkOutput("nf_busy", {31'd0, busy_a}, 32'd0);
    checkOutput("nf_fs_once", fs_cnt_a - fs_mark, 32'd1);
    to_hw_sig = 2'b00;
    tick(1);
    checkOutput("nf_hold", {30'd0, from_hw_sig_a}, 32'h1);
    tick(1);
    checkOutput("nf_clear", {30'd0, from_hw_sig_a}, 32'h0);

    // Timeout on dut_b: abort appears after 50 BUSY cycles
    doReset();
    ab_mark = ab_cnt_b;
    runToBusy();
    checkOutput("to_fs", {31'd0, frame_start_b}, 32'd1);
    tick(49);
    checkOutput("to_pre_abort", {31'd0, engine_abort_b}, 32'd0);
    checkOutput("to_pre_busy", {31'd0, busy_b}, 32'd1);
    tick(1);
    checkOutput("to_abort", {31'd0, engine_abort_b}, 32'd1);
    checkOutput("to_status", {30'd0, from_hw_sig_b}, 32'h2);
    checkOutput("to_count", {16'd0, frame_count_b}, 32'd0);
    tick(1);
    checkOutput("to_abort_once", ab_cnt_b - ab_mark, 32'd1);

    // Done in the final timeout cycle wins
    doReset();
    ab_mark = ab_cnt_b;
    runToBusy();
    tick(49);
    engine_done = 1'b1;
    tick(1);
    engine_done = 1'b0;
    checkOutput("race_status", {30'd0, from_hw_sig_b}, 32'h1);
    checkOutput("race_count", {16'd0, frame_count_b}, 32'd1);
    tick(2);
    checkOutput("race_no_abort", ab_cnt_b - ab_mark, 32'd0);

    // ABORT at cycle 20 of BUSY; later engine_done ignored
    doReset();
    ab_mark = ab_cnt_a;
    runToBusy();
    tick(19);
    to_hw_sig = 2'b11;
    tick(1);
    checkOutput("ab_latency", {31'd0, engine_abort_a}, 32'd0);
    tick(1);
    checkOutput("ab_pulse", {31'd0, engine_abort_a}, 32'd1);
    checkOutput("ab_status", {30'd0, from_hw_sig_a}, 32'h2);
    tick(2);
    engine_done = 1'b1;
    tick(1);
    engine_done = 1'b0;
    tick(1);
    checkOutput("ab_once", ab_cnt_a - ab_mark, 32'd1);
    checkOutput("ab_status_hold", {30'd0, from_hw_sig_a}, 32'h2);
    checkOutput("ab_count", {16'd0, frame_count_a}, 32'd0);

    // Wrap: preload 0xFFFF and finish one frame
    doReset();
    force dut_a.frame_count = 16'hFFFF;
    #1;
    release dut_a.frame_count;
    runToBusy();
    tick(5);
    engine_done = 1'b1;
    tick(1);
    engine_done = 1'b0;
    checkOutput("wrap_count", {16'd0, frame_count_a}, 32'h0);
    checkOutput("wrap_status", {30'd0, from_hw_sig_a}, 32'h1);
    to_hw_sig = 2'b00;
    tick(2);
    checkOutput("wrap_idle", {30'd0, from_hw_sig_a}, 32'h0);

    // Cancel: REQ dropped in ARMED, stray engine_done ignored
    fs_mark = fs_cnt_a;
    applyStimulus(2'b01, 1'b0, 1'b0);
    tick(2);
    checkOutput("cx_armed", {31'd0, busy_a}, 32'd1);
    engine_done = 1'b1;
    tick(1);
    engine_done = 1'b0;
    to_hw_sig = 2'b00;
    tick(2);
    checkOutput("cx_idle", {31'd0, busy_a}, 32'd0);
    vsync = 1'b1;
    tick(5);
    checkOutput("cx_no_fs", fs_cnt_a - fs_mark, 32'd0);
    checkOutput("cx_count", {16'd0, frame_count_a}, 32'h0);
    checkOutput("cx_status", {30'd0, from_hw_sig_a}, 32'h0);

    // Reset mid-BUSY with vsync high through release
    doReset();
    runToBusy();
    tick(10);
    ab_mark = ab_cnt_a;
    reset = 1'b1;
    tick(1);
    checkOutput("mr_abort", {31'd0, engine_abort_a}, 32'd0);
    checkOutput("mr_busy", {31'd0, busy_a}, 32'd0);
    checkOutput("mr_status", {30'd0, from_hw_sig_a}, 32'h0);
    checkOutput("mr_fs", {31'd0, frame_start_a}, 32'd0);
    tick(2);
    reset = 1'b0;
    fs_mark = fs_cnt_a;
    tick(10);
    checkOutput("mr_rearmed", {31'd0, busy_a}, 32'd1);
    checkOutput("mr_no_fs", fs_cnt_a - fs_mark, 32'd0);
    checkOutput("mr_no_abort", ab_cnt_a - ab_mark, 32'd0);

    checkOutput("start_abort_excl", both_high, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/cam_soc_hw_seq_ctrl.md
CAM_SOC_HW_SEQ_CTRL -- requirements
Module: cam_soc_hw_seq_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 2000000: cycles allowed in BUSY before a timeout error.
REQ-002 Parameter TMO_W, default 24: timeout counter width; must satisfy TIMEOUT_CYCLES < 2**TMO_W.
REQ-003 clk  in  1: single clock for all logic.
REQ-004 reset  in  1: synchronous, active-high reset.
REQ-005 to_hw_sig  in  2: command word from the CPU output port; bit0 = REQ (level), bit1 = ABORT (level).
REQ-006 vsync  in  1: camera frame sync, asynchronous to clk.
REQ-007 engine_done  in  1: one-cycle pulse from the encryption engine when a frame completes.
REQ-008 frame_start  out  1: one-cycle pulse that starts the engine.
REQ-009 engine_abort  out  1: one-cycle pulse that cancels the engine.
REQ-010 from_hw_sig  out  2: status to the CPU input port; bit0 = DONE, bit1 = ERROR.
REQ-011 busy  out  1: high in ARMED and BUSY.
REQ-012 frame_count  out  16: completed-frame counter.

Function
REQ-013 The FSM SHALL have states IDLE, ARMED, BUSY, DONE and ERROR.
REQ-014 Both to_hw_sig bits SHALL be registered once before use, giving 1 cycle of command latency.
REQ-015 vsync SHALL pass through a 2-flop synchronizer followed by a rising-edge detector (vs_rise).
REQ-016 IDLE -> ARMED when REQ=1 and ABORT=0.
REQ-017 ARMED -> BUSY on vs_rise; frame_start SHALL pulse in the same cycle the state becomes BUSY.
REQ-018 BUSY -> DONE on engine_done; frame_count SHALL increment by 1, wrapping 0xFFFF -> 0x0000.
REQ-019 The BUSY timeout counter SHALL clear on entry to BUSY and count every cycle in BUSY.
REQ-020 When the BUSY timeout counter reaches TIMEOUT_CYCLES-1 without engine_done: BUSY -> ERROR and engine_abort pulses.
REQ-021 If engine_done and the timeout occur in the same cycle, done SHALL win: go to DONE, no abort pulse.
REQ-022 ABORT=1 in ARMED or BUSY SHALL go to ERROR; engine_abort pulses only if the state was BUSY.
REQ-023 ABORT takes priority over engine_done arriving in the same cycle; frame_count does not increment.
REQ-024 DONE and ERROR SHALL hold until REQ=0, then go to IDLE, clearing from_hw_sig in the following cycle.
REQ-025 REQ falling in ARMED SHALL return to IDLE with no output pulses.
REQ-026 REQ falling in BUSY SHALL be ignored; the frame completes or times out first.
REQ-027 ABORT=1 in IDLE SHALL be ignored; IDLE -> ARMED requires ABORT=0.
REQ-028 from_hw_sig[0] SHALL be 1 exactly while in DONE; from_hw_sig[1] SHALL be 1 exactly while in ERROR.
REQ-029 engine_done outside BUSY SHALL be ignored.
REQ-030 frame_start and engine_abort SHALL never both be high in the same cycle.
REQ-031 All outputs SHALL be registered.

Reset
REQ-032 While reset=1 on a clk edge:
- state = IDLE
- frame_start, engine_abort, busy = 0
- from_hw_sig = 2'b00
- frame_count = 0
- timeout counter, synchronizer and edge-detector flops = 0
REQ-033 Reset asserted mid-BUSY SHALL NOT emit engine_abort; the engine is reset from the same source.
REQ-034 A vsync high level present at reset release SHALL NOT produce vs_rise.

Structure
REQ-035 Package cam_soc_hs_pkg SHALL hold:
- the state enum
- bit-index constants REQ_BIT=0, ABORT_BIT=1, DONE_BIT=0, ERR_BIT=1
REQ-036 Sub-module cam_soc_sync_edge (2-flop synchronizer plus rising-edge pulse) SHALL be instantiated for vsync; everything else stays flat.

Verification
REQ-037 Normal frame: REQ=1, vsync rises 10 cycles later, engine_done 100 cycles after frame_start -> frame_start pulses once, from_hw_sig=01, frame_count=1; REQ=0 -> from_hw_sig=00.
REQ-038 Timeout: TIMEOUT_CYCLES=50, no engine_done -> engine_abort pulses on cycle 50 of BUSY, from_hw_sig=10, frame_count unchanged.
REQ-039 Abort in BUSY: to_hw_sig=11 at cycle 20 of BUSY -> ERROR, one engine_abort pulse; a later engine_done is ignored.
REQ-040 Done-versus-timeout race: engine_done in the final timeout cycle -> DONE, no abort pulse, frame_count increments.
REQ-041 Wrap and cancel:
- preload frame_count to 0xFFFF via 65535 frames, or force it in the bench; complete one more frame -> 0x0000
- REQ dropped in ARMED -> IDLE with no frame_start
REQ-042 Reset mid-BUSY -> next cycle all outputs 0, state IDLE; vsync held high through reset release -> no frame_start.
